// File: rtl/axil_gpio_bank.sv
// axil_gpio_bank: AXI4-Lite GPIO bank with per-channel OUT/OE/EN/STAT registers,
// synchronised inputs and a registered rising-edge interrupt.
module axil_gpio_bank #(
  parameter int NCH = 2,
  parameter int W = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [7:0]       s_axi_awaddr,
  input  logic             s_axi_awvalid,
  output logic             s_axi_awready,
  input  logic [31:0]      s_axi_wdata,
  input  logic [3:0]       s_axi_wstrb,
  input  logic             s_axi_wvalid,
  output logic             s_axi_wready,
  output logic [1:0]       s_axi_bresp,
  output logic             s_axi_bvalid,
  input  logic             s_axi_bready,
  input  logic [7:0]       s_axi_araddr,
  input  logic             s_axi_arvalid,
  output logic             s_axi_arready,
  output logic [31:0]      s_axi_rdata,
  output logic [1:0]       s_axi_rresp,
  output logic             s_axi_rvalid,
  input  logic             s_axi_rready,
  input  logic [NCH*W-1:0] gpio_i,
  output logic [NCH*W-1:0] gpio_o,
  output logic [NCH*W-1:0] gpio_oe,
  output logic             irq
);
  localparam int N = NCH * W;
  logic [N-1:0]  r_out, r_oe, r_en, r_stat, r_s1, r_s2, r_s2d;
  logic          w_wr, w_rd, w_werr, w_rerr;
  logic [31:0]   w_mask, w_wd;
  logic [N-1:0]  w_rise;
  logic [W-1:0]  w_rv;
  assign w_wr = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
  assign w_rd = s_axi_arvalid & ~s_axi_rvalid;
  assign w_werr = int'(s_axi_awaddr[7:5]) >= NCH || s_axi_awaddr[4:0] > 5'h10 || s_axi_awaddr[1:0] != 2'b00;
  assign w_rerr = int'(s_axi_araddr[7:5]) >= NCH || s_axi_araddr[4:0] > 5'h10 || s_axi_araddr[1:0] != 2'b00;
  assign w_mask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}}, {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
  assign w_wd = s_axi_wdata & w_mask;
  assign w_rise = r_s2 & ~r_s2d;
  assign gpio_o = r_out;
  assign gpio_oe = r_oe;
  always_comb begin
    w_rv = '0;
    for (int i = 0; i < NCH; i++)
      if (s_axi_araddr[7:5] == 3'(i))
        w_rv = s_axi_araddr[4:2] == 3'd0 ? r_out[i*W +: W] :
               s_axi_araddr[4:2] == 3'd1 ? r_s2[i*W +: W] :
               s_axi_araddr[4:2] == 3'd2 ? r_oe[i*W +: W] :
               s_axi_araddr[4:2] == 3'd3 ? r_en[i*W +: W] : r_stat[i*W +: W];
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      {r_out, r_oe, r_en, r_stat, r_s1, r_s2, r_s2d} <= '0;
      {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, irq} <= '0;
      s_axi_bresp <= '0;
      s_axi_rresp <= '0;
      s_axi_rdata <= '0;
    end else begin
      s_axi_awready <= w_wr;
      s_axi_wready <= w_wr;
      s_axi_arready <= w_rd;
      if (w_wr) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= w_werr ? 2'd2 : 2'd0;
      end else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (w_rd) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rresp <= w_rerr ? 2'd2 : 2'd0;
        s_axi_rdata <= w_rerr ? 32'd0 : 32'(w_rv);
      end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
      r_s1 <= gpio_i;
      r_s2 <= r_s1;
      r_s2d <= r_s2;
      irq <= |(r_stat & r_en);
      r_stat <= r_stat | w_rise;
      // the W1C below re-ORs the rise so a fresh edge wins over a same-cycle clear
      for (int i = 0; i < NCH; i++)
        if (w_wr && !w_werr && s_axi_awaddr[7:5] == 3'(i)) begin
          if (s_axi_awaddr[4:2] == 3'd0) r_out[i*W +: W] <= (r_out[i*W +: W] & ~w_mask[W-1:0]) | w_wd[W-1:0];
          if (s_axi_awaddr[4:2] == 3'd1) r_out[i*W +: W] <= r_out[i*W +: W] ^ w_wd[W-1:0];
          if (s_axi_awaddr[4:2] == 3'd2) r_oe[i*W +: W] <= (r_oe[i*W +: W] & ~w_mask[W-1:0]) | w_wd[W-1:0];
          if (s_axi_awaddr[4:2] == 3'd3) r_en[i*W +: W] <= (r_en[i*W +: W] & ~w_mask[W-1:0]) | w_wd[W-1:0];
          if (s_axi_awaddr[4:2] == 3'd4) r_stat[i*W +: W] <= (r_stat[i*W +: W] & ~w_wd[W-1:0]) | w_rise[i*W +: W];
        end
    end
  end
endmodule

// File: doc/axil_gpio_bank.md
AXIL_GPIO_BANK -- requirements
Module: axil_gpio_bank

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning the number of GPIO channels (legal range 1..8).
REQ-002 SHALL have parameter W, default 32, meaning the pin width per channel (legal range 1..32).
REQ-003 SHALL have port aclk  input  1  clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have AXI4-Lite write ports:
- s_axi_awaddr  input  8
- s_axi_awvalid  input  1
- s_axi_awready  output  1
- s_axi_wdata  input  32
- s_axi_wstrb  input  4
- s_axi_wvalid  input  1
- s_axi_wready  output  1
- s_axi_bresp  output  2
- s_axi_bvalid  output  1
- s_axi_bready  input  1
REQ-006 SHALL have AXI4-Lite read ports:
- s_axi_araddr  input  8
- s_axi_arvalid  input  1
- s_axi_arready  output  1
- s_axi_rdata  output  32
- s_axi_rresp  output  2
- s_axi_rvalid  output  1
- s_axi_rready  input  1
REQ-007 SHALL have pin and interrupt ports:
- gpio_i  input  NCH*W  asynchronous pins; channel c occupies bits [c*W +: W]
- gpio_o  output  NCH*W  output values
- gpio_oe  output  NCH*W  output enables, 1 = drive
- irq  output  1  level interrupt

Function
REQ-008 SHALL decode the channel as c = awaddr[7:5] (araddr[7:5] for reads) and the offset as bits [4:0], with these offsets:
- 0x00 OUT: read/write
- 0x04: write XORs the write data into OUT; read returns IN (synchronised pins)
- 0x08 OE: read/write
- 0x0C EN: read/write rising-edge interrupt enable
- 0x10 STAT: read status; write-1-to-clear
REQ-009 SHALL accept a write in the cycle where awvalid, wvalid and !bvalid are all true: awready and wready pulse high for exactly 1 cycle on the next edge, and bvalid rises on that same edge.
REQ-010 SHALL hold bvalid until bready is sampled high, and SHALL NOT accept a new write while bvalid=1.
REQ-011 SHALL accept a read in the cycle where arvalid and !rvalid are true: arready pulses for 1 cycle, rvalid rises on the same edge, and rdata/rresp are decoded from araddr.
REQ-012 SHALL hold rvalid and rdata stable until rready is sampled high; reads and writes are independent and may complete in the same cycle.
REQ-013 SHALL respond SLVERR (2) when c>=NCH, offset>0x10, or addr[1:0]!=0; such writes change no state, and such reads return rdata=0.
REQ-014 SHALL respond OKAY (0) to all other accesses.
REQ-015 SHALL apply writes byte-wise under wstrb; bits at index W and above are ignored on write and read as 0.
REQ-016 SHALL pass each gpio_i bit through a 2-flop synchroniser (sync2), then a delay flop (sync2_d).
REQ-017 SHALL return sync2 for an IN read.
REQ-018 SHALL set STAT bit n on any edge where sync2[n]=1 and sync2_d[n]=0, regardless of EN.
REQ-019 SHALL give a set priority over a same-cycle W1C on that bit.
REQ-020 SHALL register irq = OR over all channels of (STAT & EN), so irq lags STAT by 1 cycle.
REQ-021 SHALL update OUT, OE and EN on the write-acceptance edge, so gpio_o and gpio_oe change on that same edge.
REQ-022 SHALL make a read of a register in the cycle after a write to it return the new value.

Reset
REQ-023 SHALL, while aresetn=0 at an edge, clear the following to 0:
- OUT, OE, EN, STAT
- sync2, sync2_d and the first synchroniser stage
- irq
- all ready/valid outputs
- bresp, rresp, rdata
REQ-024 SHALL drop any pending bvalid/rvalid on reset mid-transaction.
REQ-025 SHALL NOT set any STAT bit in the first cycle after reset release, because sync2_d=0 and sync2=0.

Verification
REQ-026 Write 0xA5A5_0000 to 0x00, then 0x0000_FFFF to 0x24 (NCH=2) -> gpio_o[31:0]=0xA5A5_0000, gpio_o[63:32]=0x0000_FFFF, both bresp=0, each bvalid held until bready.
REQ-027 Write OUT=0xFF00_FF00, then XOR 0xFFFF_FFFF to 0x04 -> read 0x00 returns 0x00FF_00FF; a write to 0x00 with wstrb=0b0001 and data 0x12 gives 0x00FF_0012.
REQ-028 EN@0x0C=0x1; gpio_i[0] rises at cycle 0 -> STAT@0x10 bit0=1 at the 3rd edge, irq=1 at the 4th edge; W1C 0x1 -> irq=0 one cycle after STAT clears; a read of 0x04 returns bit0=1.
REQ-029 W1C of bit0 on the same edge a new rising edge of bit0 is detected -> STAT bit0 stays 1.
REQ-030 Access 0x44 with NCH=2, 0x14, and 0x02 -> bresp/rresp=2, rdata=0, no register changes.
REQ-031 Assert aresetn=0 while bvalid=1 and rvalid=1 with OUT=0xFFFF_FFFF -> next edge bvalid=0, rvalid=0, gpio_o=0, irq=0.
